fetch_prefetch_unit: RTL and testbench

- Instruction fetch stage that owns the program counter and issues word reads to an instruction memory with a valid/ready request and in-order response interface.
- Buffers returned instructions, tagged with their PC, in a small prefetch FIFO that feeds the decode/control stage over a valid/ready handshake.
- Accepts branch/jump redirects from the execute stage: flushes buffered instructions and discards in-flight responses.

---
 rtl/fetch_prefetch_unit.sv | 147 ++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to instruction memory,
// buffers PC-tagged responses in a prefetch FIFO and handles execute redirects.
// Optional statistics counters are built when FETCH_STATS_EN is defined.
module fetch_prefetch_unit #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_dropped,
  output logic [31:0] stat_redirects
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [31:0]   fetch_pc;
  logic [IW-1:0] inflight;
  logic [IW-1:0] drop;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   fifo_data [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   pc_q      [MAX_OUTSTANDING];
  logic [QW-1:0] q_rd;
  logic [QW-1:0] q_wr;

  logic        req_fire;
  logic        resp_ok;
  logic        discard;
  logic        push;
  logic        pop;
  logic [31:0] occupancy;

  // Request credit, response classification and FIFO head outputs
  always_comb begin
    occupancy      = 32'(count) + 32'(inflight);
    imem_req_valid = !rst && !redirect_valid &&
                     (32'(inflight) < MAX_OUTSTANDING) && (occupancy < DEPTH);
    imem_req_addr  = fetch_pc;
    req_fire       = imem_req_valid && imem_req_ready;
    // A response with nothing in flight is a protocol error and is ignored
    resp_ok        = imem_resp_valid && (inflight != '0);
    discard        = resp_ok && (redirect_valid || (drop != '0));
    push           = resp_ok && !discard;
    inst_valid     = (count != '0);
    pop            = inst_valid && inst_ready;
    inst_data      = inst_valid ? fifo_data[rd_ptr] : '0;
    inst_pc        = inst_valid ? fifo_pc[rd_ptr]   : '0;
  end

  // PC, in-flight/drop accounting, request-PC queue pointers and FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      q_rd     <= '0;
      q_wr     <= '0;
    end else begin
      if (redirect_valid)
        fetch_pc <= redirect_pc & ~32'h3;
      else if (req_fire)
        fetch_pc <= fetch_pc + 32'd4;

      case ({req_fire, resp_ok})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase

      // Every response still in flight after a redirect belongs to the old path
      if (redirect_valid)
        drop <= inflight - IW'(resp_ok);
      else if (resp_ok && (drop != '0))
        drop <= drop - 1'b1;

      // Dropped responses still retire their queue entry to keep PCs aligned
      if (req_fire)
        q_wr <= (32'(q_wr) == MAX_OUTSTANDING - 1) ? '0 : q_wr + 1'b1;
      if (resp_ok)
        q_rd <= (32'(q_rd) == MAX_OUTSTANDING - 1) ? '0 : q_rd + 1'b1;

      if (redirect_valid) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage for FIFO entries and request PCs
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= imem_resp_data;
      fifo_pc[wr_ptr]   <= pc_q[q_rd];
    end
    if (req_fire)
      pc_q[q_wr] <= fetch_pc;
  end

`ifdef FETCH_STATS_EN
  // Free-running event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_fetched   <= '0;
      stat_dropped   <= '0;
      stat_redirects <= '0;
    end else begin
      if (push)           stat_fetched   <= stat_fetched + 32'd1;
      if (discard)        stat_dropped   <= stat_dropped + 32'd1;
      if (redirect_valid) stat_redirects <= stat_redirects + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: an in-order memory model with
// variable latency plus a queue-based model of the fetch stream rules.
module tb_fetch_prefetch_unit;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_dropped, stat_redirects;
`endif

  fetch_prefetch_unit #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
`ifdef FETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_dropped(stat_dropped),
    .stat_redirects(stat_redirects)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int unsigned due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  req_t        pend[$];   // requests accepted by memory, not yet answered
  ent_t        mf[$];     // expected FIFO contents, head first
  logic [31:0] m_pc;
  int unsigned m_drop;
  int unsigned cyc;
  int unsigned last_due;
  int unsigned lat_lo, lat_hi;
  int unsigned checks, failures;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_true(input string tag, input bit cond);
    checks++;
    assert (cond) else begin
      failures++;
      $error("FAIL %s observed=0 expected=1 (cycle %0d)", tag, cyc);
    end
  endtask

  // Assert reset asynchronously, check outputs immediately, then release
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_req_valid",  32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_data",  inst_data, 32'd0);
    chk("rst_inst_pc",    inst_pc, 32'd0);
    pend.delete();
    mf.delete();
    m_drop = 0;
    m_pc = RPC;
    last_due = 0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    inst_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc += 2;
    rst = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs, advance the model
  task automatic cycle(input bit rv, input logic [31:0] rpc, input bit rdy, input bit ir);
    bit resp, exp_rq;
    logic [31:0] raddr;
    int unsigned infl, due;
    req_t rq;
    ent_t e;
    infl  = pend.size();
    resp  = (pend.size() > 0) && (pend[0].due <= cyc);
    raddr = resp ? pend[0].addr : 32'h0;
    redirect_valid  = rv;
    redirect_pc     = rpc;
    imem_req_ready  = rdy;
    inst_ready      = ir;
    imem_resp_valid = resp;
    imem_resp_data  = resp ? mem_word(raddr) : $urandom();
    #1;
    exp_rq = !rv && (infl < MAXO) && ((mf.size() + infl) < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rq));
    if (exp_rq) chk("req_addr", imem_req_addr, m_pc);
    chk("inst_valid", 32'(inst_valid), 32'(mf.size() > 0));
    if (mf.size() > 0) begin
      chk("inst_pc", inst_pc, mf[0].pc);
      chk("inst_data", inst_data, mf[0].data);
    end
    if ((mf.size() > 0) && ir) e = mf.pop_front();
    if (resp) begin
      rq = pend.pop_front();
      if (!rv) begin
        if (m_drop > 0) m_drop--;
        else mf.push_back('{rq.addr, mem_word(rq.addr)});
      end
    end
    if (exp_rq && rdy) begin
      due = cyc + $urandom_range(lat_hi, lat_lo);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{m_pc, due});
      m_pc = m_pc + 32'd4;
    end
    if (rv) begin
      mf.delete();
      m_drop = infl - 32'(resp);
      m_pc = {rpc[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    bit met;
    checks = 0; failures = 0; cyc = 0;
    lat_lo = 1; lat_hi = 1;

    // Reset state, then a straight stream with a 1-cycle memory
    do_reset();
    for (int i = 0; i < 40; i++) cycle(1'b0, '0, 1'b1, 1'b1);

    // Consumer stalled from reset: FIFO fills to DEPTH, head stays at RESET_PC
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("stall_head_pc", inst_pc, RPC);
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);

    // Reset with a full FIFO, then resume
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1, 1'b1);

    // 3-cycle memory, redirect to an unaligned target with two requests in flight
    lat_lo = 3; lat_hi = 3;
    met = 1'b0;
    for (int i = 0; i < 20 && !met; i++) begin
      if (pend.size() == 2) met = 1'b1;
      else cycle(1'b0, '0, 1'b1, 1'b1);
    end
    expect_true("wait_two_inflight", met);
    cycle(1'b1, 32'h0000_0103, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b1, 1'b1);

    // Redirect coinciding with a response and a pop
    lat_lo = 1; lat_hi = 1;
    met = 1'b0;
    for (int i = 0; i < 20 && !met; i++) begin
      if ((pend.size() > 0) && (pend[0].due <= cyc) && (mf.size() > 0)) met = 1'b1;
      else cycle(1'b0, '0, 1'b1, 1'b1);
    end
    expect_true("wait_resp_and_pop", met);
    cycle(1'b1, 32'h0000_2000, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b1);

    // Address wrap at the top of memory
    cycle(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b1);

    // Back-to-back redirects: the last one wins
    lat_lo = 2; lat_hi = 3;
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b1, 32'h0000_4000, 1'b1, 1'b1);
    cycle(1'b1, 32'h0000_8008, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b1);

    // Randomised traffic: variable latency, ready, consumer stalls and redirects
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++)
      cycle(($urandom_range(15, 0) == 0), $urandom(),
            ($urandom_range(3, 0) != 0), ($urandom_range(2, 0) != 0));

    // Random mid-stream reset and recovery
    do_reset();
    for (int i = 0; i < 200; i++)
      cycle(($urandom_range(15, 0) == 0), $urandom(),
            ($urandom_range(3, 0) != 0), ($urandom_range(2, 0) != 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
